burst_ram_arbiter: RTL and testbench

Two-port arbiter that shares one BurstRAM controller between two burst masters, for example an instruction-side and a data-side RAMIO. Each port is a copy of the `br_*` burst interface plus a `busy` back-pressure output. The arbiter grants the RAM to one port for a whole burst: one read burst, or one write burst of BURST_COUNT words. It routes read data back only to the owning port. It sits between the RAMIO instances and the BurstRAM/SDRAM IP.

---
 rtl/burst_ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// rtl/burst_ram_arbiter.sv - two-port whole-burst arbiter in front of one BurstRAM controller
// Optional round-robin tie-break when BR_ARBITER_ROUND_ROBIN_EN is defined; fixed priority (port 0) otherwise.
module burst_ram_arbiter #(
    parameter int ADDR_BITWIDTH = 4,
    parameter int DATA_BITWIDTH = 64,
    parameter int BURST_COUNT   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m0_cmd,
    input  logic                         m0_cmd_en,
    input  logic [ADDR_BITWIDTH-1:0]     m0_addr,
    input  logic [DATA_BITWIDTH-1:0]     m0_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]   m0_data_mask,
    output logic [DATA_BITWIDTH-1:0]     m0_rd_data,
    output logic                         m0_rd_data_valid,
    output logic                         m0_busy,
    input  logic                         m1_cmd,
    input  logic                         m1_cmd_en,
    input  logic [ADDR_BITWIDTH-1:0]     m1_addr,
    input  logic [DATA_BITWIDTH-1:0]     m1_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]   m1_data_mask,
    output logic [DATA_BITWIDTH-1:0]     m1_rd_data,
    output logic                         m1_rd_data_valid,
    output logic                         m1_busy,
    output logic                         br_cmd,
    output logic                         br_cmd_en,
    output logic [ADDR_BITWIDTH-1:0]     br_addr,
    output logic [DATA_BITWIDTH-1:0]     br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]   br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]     br_rd_data,
    input  logic                         br_rd_data_valid,
    input  logic                         br_busy,
    input  logic                         br_init_calib
);
    localparam int CNT_BITWIDTH = $clog2(BURST_COUNT + 1);
    localparam logic [CNT_BITWIDTH-1:0] CNT_WRITE = CNT_BITWIDTH'(BURST_COUNT - 1);
    localparam logic [CNT_BITWIDTH-1:0] CNT_READ  = CNT_BITWIDTH'(BURST_COUNT);
    localparam logic [CNT_BITWIDTH-1:0] CNT_ONE   = CNT_BITWIDTH'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} st_t;

    st_t                     st_q, st_d;
    logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;
    logic                    owner_q, owner_d;
    logic                    avail;
    logic                    gnt0, gnt1;
    logic                    sel;
    logic                    sel_cmd;
    logic                    rd_live;

`ifdef BR_ARBITER_ROUND_ROBIN_EN
    logic last_q, last_d;

    // Reset to 1 so that port 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt0) last_d = 1'b0;
        if (gnt1) last_d = 1'b1;
    end
`endif

    always_comb begin
        avail = (st_q == ST_IDLE) && !br_busy && br_init_calib;
`ifdef BR_ARBITER_ROUND_ROBIN_EN
        gnt0 = avail && m0_cmd_en && (!m1_cmd_en || last_q);
        gnt1 = avail && m1_cmd_en && (!m0_cmd_en || !last_q);
`else
        gnt0 = avail && m0_cmd_en;
        gnt1 = avail && m1_cmd_en && !m0_cmd_en;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        case (st_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d = gnt1;
                    if (gnt1 ? m1_cmd : m0_cmd) begin
                        st_d  = ST_WRITE;
                        cnt_d = CNT_WRITE;
                    end else begin
                        st_d  = ST_READ;
                        cnt_d = CNT_READ;
                    end
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) st_d = ST_IDLE;
            end
            ST_READ: begin
                if (br_rd_data_valid) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // While idle the mux follows the grant (port 0 when nobody is granted); mid-burst it follows the owner.
    always_comb begin
        sel              = (st_q == ST_IDLE) ? gnt1 : owner_q;
        sel_cmd          = sel ? m1_cmd : m0_cmd;
        br_cmd_en        = gnt0 || gnt1;
        br_cmd           = br_cmd_en && sel_cmd;
        br_addr          = sel ? m1_addr : m0_addr;
        br_wr_data       = sel ? m1_wr_data : m0_wr_data;
        br_data_mask     = sel ? m1_data_mask : m0_data_mask;
        rd_live          = (st_q == ST_READ) && br_rd_data_valid;
        m0_rd_data_valid = rd_live && !owner_q;
        m1_rd_data_valid = rd_live && owner_q;
        m0_busy          = !avail || gnt1;
        m1_busy          = !avail || gnt0;
        m0_rd_data       = br_rd_data;
        m1_rd_data       = br_rd_data;
    end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb/tb_burst_ram_arbiter.sv - directed + randomized self-checking bench for burst_ram_arbiter
// Burst-level reference model, BurstRAM behavioural model and per-port read scoreboards live here.
module tb_burst_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int BC = 4;
    localparam int NA = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [1:0]    m_cmd, m_cmd_en;
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wr_data [2];
    logic [MW-1:0] m_mask [2];
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          m0_rd_data_valid, m1_rd_data_valid, m0_busy, m1_busy;
    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data, br_rd_data;
    logic [MW-1:0] br_data_mask;
    logic          br_rd_data_valid, br_busy, br_init_calib;

    burst_ram_arbiter #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cmd(m_cmd[0]), .m0_cmd_en(m_cmd_en[0]), .m0_addr(m_addr[0]), .m0_wr_data(m_wr_data[0]),
        .m0_data_mask(m_mask[0]), .m0_rd_data(m0_rd_data), .m0_rd_data_valid(m0_rd_data_valid), .m0_busy(m0_busy),
        .m1_cmd(m_cmd[1]), .m1_cmd_en(m_cmd_en[1]), .m1_addr(m_addr[1]), .m1_wr_data(m_wr_data[1]),
        .m1_data_mask(m_mask[1]), .m1_rd_data(m1_rd_data), .m1_rd_data_valid(m1_rd_data_valid), .m1_busy(m1_busy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy), .br_init_calib(br_init_calib)
    );

    int errors = 0;
    int checks = 0;

    // Masters: one pending request each, plus the beat index of an ongoing write.
    bit            req_en [2];
    logic          req_cmd [2];
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_data [2][BC];
    logic [MW-1:0] req_mask [2];
    int            wbeat [2];
    int            nvalid [2];

    // Reference: what memory should hold and which burst currently owns the RAM.
    logic [DW-1:0] ref_mem [NA][BC];
    logic [DW-1:0] ref_wdata [BC];
    int            ref_wleft, ref_rleft, ref_owner, ref_last;
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];

    // BurstRAM behavioural model (not reset by rst_n, like the real controller).
    logic [DW-1:0] ram_mem [NA][BC];
    logic [AW-1:0] ram_waddr, ram_raddr;
    int            ram_wleft, ram_wbeat, ram_rleft, ram_rbeat, ram_rwait;
    bit            busy_on, gaps_on;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit   g [2];
        bit   avail, exp_busy, ev;
        int   w;
        logic vld, dat_ok;
        logic [DW-1:0] d;
        for (int p = 0; p < 2; p++) begin
            m_cmd_en[p]  = req_en[p];
            m_cmd[p]     = req_cmd[p];
            m_addr[p]    = req_addr[p];
            m_mask[p]    = req_mask[p];
            m_wr_data[p] = req_data[p][wbeat[p]];
        end
        br_busy          = busy_on && ($urandom_range(0, 5) == 0);
        br_rd_data_valid = (ram_rleft > 0) && (ram_rwait == 0);
        br_rd_data       = '0;
        if (br_rd_data_valid) br_rd_data = ram_mem[ram_raddr][ram_rbeat];
        #1;
        avail = (ref_wleft == 0) && (ref_rleft == 0) && !br_busy && br_init_calib;
        g[0] = 1'b0;
        g[1] = 1'b0;
        if (avail && req_en[0] && req_en[1]) begin
`ifdef BR_ARBITER_ROUND_ROBIN_EN
            w = 1 - ref_last;
`else
            w = 0;
`endif
            g[w] = 1'b1;
        end else if (avail && req_en[0]) begin
            g[0] = 1'b1;
        end else if (avail && req_en[1]) begin
            g[1] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            exp_busy = (ref_wleft > 0) || (ref_rleft > 0) || br_busy || !br_init_calib || g[1-p];
            chk(p == 0 ? "m0_busy" : "m1_busy", DW'(p == 0 ? m0_busy : m1_busy), DW'(exp_busy));
        end
        chk("br_cmd_en", DW'(br_cmd_en), DW'(g[0] || g[1]));
        if (g[0] || g[1]) begin
            w = g[1] ? 1 : 0;
            chk("grant_cmd", DW'(br_cmd), DW'(req_cmd[w]));
            chk("grant_addr", DW'(br_addr), DW'(req_addr[w]));
            chk("grant_wdata", br_wr_data, req_data[w][0]);
            chk("grant_mask", DW'(br_data_mask), DW'(req_mask[w]));
        end else if (ref_wleft > 0) begin
            chk("write_word", br_wr_data, ref_wdata[BC - ref_wleft]);
            chk("write_mask", DW'(br_data_mask), DW'(req_mask[ref_owner]));
        end else if (ref_rleft == 0) begin
            chk("idle_addr", DW'(br_addr), DW'(m_addr[0]));
            chk("idle_cmd", DW'(br_cmd), '0);
        end
        for (int p = 0; p < 2; p++) begin
            ev  = br_rd_data_valid && (ref_rleft > 0) && (ref_owner == p);
            vld = (p == 0) ? m0_rd_data_valid : m1_rd_data_valid;
            chk(p == 0 ? "m0_rd_valid" : "m1_rd_valid", DW'(vld), DW'(ev));
            if (vld === 1'b1) nvalid[p]++;
            if (ev) begin
                d = '0;
                dat_ok = 1'b0;
                if (p == 0 && exp_q0.size() > 0) begin d = exp_q0.pop_front(); dat_ok = 1'b1; end
                if (p == 1 && exp_q1.size() > 0) begin d = exp_q1.pop_front(); dat_ok = 1'b1; end
                chk("exp_word_available", DW'(dat_ok), DW'(1));
                chk(p == 0 ? "m0_rd_data" : "m1_rd_data", p == 0 ? m0_rd_data : m1_rd_data, d);
            end
        end
        // Masters advance on the model's grant decision.
        for (int p = 0; p < 2; p++) begin
            if (wbeat[p] > 0) wbeat[p] = (wbeat[p] + 1 == BC) ? 0 : wbeat[p] + 1;
            if (g[p]) begin
                req_en[p] = 1'b0;
                if (req_cmd[p]) wbeat[p] = 1;
            end
        end
        // Reference burst bookkeeping.
        if (ref_wleft > 0) begin
            ref_wleft--;
        end else if (ref_rleft > 0) begin
            if (br_rd_data_valid) ref_rleft--;
        end else if (g[0] || g[1]) begin
            w = g[1] ? 1 : 0;
            ref_owner = w;
            ref_last  = w;
            if (req_cmd[w]) begin
                for (int k = 0; k < BC; k++) begin
                    ref_wdata[k] = req_data[w][k];
                    ref_mem[req_addr[w]][k] = req_data[w][k];
                end
                ref_wleft = BC - 1;
            end else begin
                for (int k = 0; k < BC; k++) begin
                    if (w == 0) exp_q0.push_back(ref_mem[req_addr[w]][k]);
                    else        exp_q1.push_back(ref_mem[req_addr[w]][k]);
                end
                ref_rleft = BC;
            end
        end
        // RAM model reacts to what the arbiter actually drives.
        if (ram_wleft > 0) begin
            ram_mem[ram_waddr][ram_wbeat] = br_wr_data;
            ram_wbeat++;
            ram_wleft--;
        end else if (br_cmd_en === 1'b1 && br_cmd === 1'b1) begin
            ram_mem[br_addr][0] = br_wr_data;
            ram_waddr = br_addr;
            ram_wbeat = 1;
            ram_wleft = BC - 1;
        end
        if (br_cmd_en === 1'b1 && br_cmd === 1'b0) begin
            ram_raddr = br_addr;
            ram_rbeat = 0;
            ram_rleft = BC;
            ram_rwait = $urandom_range(1, 3);
        end else if (br_rd_data_valid) begin
            ram_rbeat++;
            ram_rleft--;
            ram_rwait = gaps_on ? $urandom_range(0, 1) : 0;
        end else if (ram_rwait > 0) begin
            ram_rwait--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input int p, input logic cmd, input logic [AW-1:0] addr);
        req_en[p]   = 1'b1;
        req_cmd[p]  = cmd;
        req_addr[p] = addr;
        req_mask[p] = MW'($urandom);
        for (int k = 0; k < BC; k++) req_data[p][k] = {$urandom, $urandom};
    endtask

    task automatic drain();
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < 300) begin
            done = !req_en[0] && !req_en[1] && wbeat[0] == 0 && wbeat[1] == 0 &&
                   ref_wleft == 0 && ref_rleft == 0 && ram_rleft == 0 && ram_wleft == 0;
            if (!done) step();
            n++;
        end
        chk("drain_in_budget", DW'(done), DW'(1));
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req_en[p] = 1'b0;
            wbeat[p]  = 0;
        end
        ref_wleft = 0;
        ref_rleft = 0;
        ref_owner = 0;
        ref_last  = 1;
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < cycles; i++) step();
        rst_n = 1'b1;
    endtask

    int n0, n1, lim;

    initial begin
        for (int a = 0; a < NA; a++)
            for (int k = 0; k < BC; k++) begin
                ram_mem[a][k] = {32'(a), 32'(k)};
                ref_mem[a][k] = {32'(a), 32'(k)};
            end
        for (int p = 0; p < 2; p++) begin
            req_cmd[p]  = 1'b0;
            req_addr[p] = '0;
            req_mask[p] = '0;
            nvalid[p]   = 0;
            for (int k = 0; k < BC; k++) req_data[p][k] = '0;
        end
        ram_wleft = 0; ram_rleft = 0; ram_rwait = 0; ram_wbeat = 0; ram_rbeat = 0;
        ram_waddr = '0; ram_raddr = '0;
        busy_on = 1'b0;
        gaps_on = 1'b0;
        br_init_calib = 1'b0;
        do_reset(2);

        // Calibration gate: port 0 read to addr 2 must wait until init_calib rises.
        issue(0, 1'b0, 4'd2);
        for (int i = 0; i < 4; i++) step();
        br_init_calib = 1'b1;
        drain();

        // Port 1 writes 0x11..0x44 at addr 5, port 0 reads it back.
        issue(1, 1'b1, 4'd5);
        for (int k = 0; k < BC; k++) req_data[1][k] = DW'(8'h11 * (k + 1));
        drain();
        n0 = nvalid[0];
        n1 = nvalid[1];
        issue(0, 1'b0, 4'd5);
        drain();
        chk("p0_read_count", DW'(nvalid[0] - n0), DW'(BC));
        chk("p1_no_valids", DW'(nvalid[1] - n1), '0);
        chk("addr5_last_word", ref_mem[5][BC-1], 64'h44);

        // Two ties in a row, then contention during a write burst.
        gaps_on = 1'b1;
        for (int t = 0; t < 2; t++) begin
            issue(0, 1'b0, 4'd1);
            issue(1, 1'b0, 4'd3);
            drain();
        end
        issue(0, 1'b1, 4'd7);
        step();
        issue(1, 1'b0, 4'd7);
        drain();

        // Reset after two of four read words.
        n0 = nvalid[0];
        issue(0, 1'b0, 4'd5);
        lim = 0;
        while (nvalid[0] - n0 < 2 && lim < 50) begin
            step();
            lim++;
        end
        chk("two_words_before_reset", DW'(nvalid[0] - n0), DW'(2));
        do_reset(1);
        n0 = nvalid[0];
        n1 = nvalid[1];
        lim = 0;
        while (ram_rleft > 0 && lim < 50) begin
            step();
            lim++;
        end
        chk("no_valids_after_reset", DW'(nvalid[0] + nvalid[1] - n0 - n1), '0);
        issue(0, 1'b0, 4'd5);
        drain();
        chk("fresh_read_count", DW'(nvalid[0] - n0), DW'(BC));

        // Randomized traffic with back-pressure and read gaps.
        busy_on = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++)
                if (!req_en[p] && wbeat[p] == 0 && $urandom_range(0, 3) == 0)
                    issue(p, 1'(($urandom_range(0, 1))), AW'($urandom_range(0, NA - 1)));
            step();
        end
        busy_on = 1'b0;
        drain();
        chk("scoreboard0_empty", DW'(exp_q0.size()), '0);
        chk("scoreboard1_empty", DW'(exp_q1.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
